key_entry_sequencer: RTL and testbench
======================================

# key_entry_sequencer

Sequential consumer of the mouse-keypad decoder outputs (`newDigit`, `newOp`, `clickedMatrix`). Turns each click into exactly one key event, accumulates decimal digits into binary operands, latches the operator, and issues a request/acknowledge transaction to the arithmetic core on `=`. It also captures the returned result for the VGA display path.

## Interface
- `WIDTH`, 16, operand/result/display width in bits.
- `MAX_DIGITS`, 4, maximum decimal digits per operand. Legal only if 10^MAX_DIGITS − 1 < 2^WIDTH.
- `clk` in 1: system clock, the same clock as the keypad decoder and the VGA/mouse logic.
- `reset_n` in 1: reset, asynchronous and active-low.
- `newDigit` in 1: level, high while a digit square is clicked.
- `newOp` in 1: level, high while an operator square is clicked.
- `clickedMatrix` in 4: key code. Digits are 0–9. Operators are 1 = `*`, 2 = `+`, 3 = `-`, 4 = `/`, 14 = `=`.
- `calcAck` in 1: arithmetic core accepted the request.
- `resultValid` in 1: one-cycle pulse, `result`/`calcErr` valid.
- `result` in WIDTH: result from the arithmetic core.
- `calcErr` in 1: error flag (divide by zero, overflow), qualified by `resultValid`.
- `operandA` out WIDTH: first operand.
- `operandB` out WIDTH: second operand.
- `opCode` out 4: latched operator code.
- `calcReq` out 1: request to the arithmetic core.
- `displayValue` out WIDTH: value to render on screen.
- `errorFlag` out 1: last result was an error.
- `entryState` out 3: current FSM state, for debug.

## Operation
- Event detect:
  - Register `press = newDigit | newOp` as `pressQ`. An event fires in the cycle where `press & ~pressQ`.
  - Holding the click produces no further events.
  - If both `newDigit` and `newOp` are high, the event is treated as a digit.
- Ignored events:
  - A digit event with code > 9.
  - An op event with a code outside {1, 2, 3, 4, 14}.
- Accumulation: `X ← X*10 + code`, computed in WIDTH bits, with a per-operand digit counter.
  - When the counter equals MAX_DIGITS, further digits are ignored and X is unchanged.
- States and encodings: ENTER_A = 0, ENTER_B = 1, REQUEST = 2, WAIT_RES = 3, SHOW_RES = 4.
- ENTER_A:
  - Digit: accumulate into `operandA`; `displayValue ← operandA` (new value).
  - Op 1–4: `opCode ← code`; `operandB ← 0`; B counter ← 0; `displayValue ← 0`; go to ENTER_B.
  - `=`: ignored.
- ENTER_B:
  - Digit: accumulate into `operandB`; update `displayValue`.
  - Op 1–4 with B counter = 0: replace `opCode`.
  - Op 1–4 with B counter > 0: ignored.
  - `=` with B counter > 0: go to REQUEST.
  - `=` with B counter = 0: ignored.
- REQUEST:
  - `calcReq = 1`; `operandA`, `operandB` and `opCode` are held stable.
  - `calcAck = 1` sampled: go to WAIT_RES.
  - All key events are ignored.
- WAIT_RES:
  - `resultValid = 1`: `displayValue ← result`; `errorFlag ← calcErr`; go to SHOW_RES.
  - All key events are ignored.
- SHOW_RES:
  - Digit: `operandA ← code`; A counter ← 1; `errorFlag ← 0`; `displayValue ← code`; go to ENTER_A.
  - Op 1–4 with `errorFlag = 0`: chain the calculation. `operandA ← displayValue`; A counter ← MAX_DIGITS (no appending to a result); `opCode ← code`; clear B; `displayValue ← 0`; go to ENTER_B.
  - Op 1–4 with `errorFlag = 1`: ignored.
  - `=`: ignored.

## Timing
- Reset (asynchronous, immediate):
  - State ENTER_A.
  - `operandA`, `operandB`, `displayValue`, counters: 0.
  - `opCode` 0, `calcReq` 0, `errorFlag` 0, `pressQ` 0.
- Every output is registered.
- Key-event latency: an event detected in cycle n is visible on outputs and state in cycle n+1.
- `calcReq` rises the cycle after the `=` event is detected.
- `calcReq` stays high until `calcAck` is sampled high at clock edge k; it is low from cycle k+1.
- The arithmetic core must not assert `resultValid` before acknowledging.
- `resultValid` is honoured only in WAIT_RES; a pulse arriving in any other state is dropped.
- `resultValid` may arrive in the same cycle as the state enters WAIT_RES, or any time later. There is no timeout.
- If `calcAck` and `resultValid` are both high in REQUEST, only `calcAck` is acted on.
- `reset_n` low during REQUEST or WAIT_RES drops `calcReq` asynchronously. A later `resultValid` is ignored, because the state is then ENTER_A.

## Test plan
- Entry and request:
  - Stimulus: click 1, 2, `+` (code 2), 3, 4, `=`.
  - Required: `operandA` = 12, `opCode` = 2, `operandB` = 34; `calcReq` rises one cycle after the `=` edge and falls the cycle after `calcAck`.
  - Then `resultValid` with `result` = 46 → `displayValue` = 46, state SHOW_RES.
- Held click:
  - Stimulus: `newDigit` high for 50 cycles with code 7.
  - Required: `operandA` = 7 (single event).
- Digit cap:
  - Stimulus: digits 9, 8, 7, 6, 5.
  - Required: `operandA` = 9876, A counter = 4, `displayValue` = 9876.
- Chaining and restart:
  - Stimulus: after result 46, press `*` (code 1), 2, `=`, then ack, then `resultValid` with `result` = 92.
  - Required: `operandA` = 46, `operandB` = 2, `opCode` = 1, `displayValue` = 92.
  - Stimulus: then press digit 5.
  - Required: `operandA` = 5, state ENTER_A.
- Error path:
  - Stimulus: 8, `/`, 0, `=`, ack, `resultValid` with `calcErr` = 1.
  - Required: `errorFlag` = 1.
  - Stimulus: press `+`.
  - Required: ignored, state stays SHOW_RES.
  - Stimulus: press digit 3.
  - Required: `errorFlag` = 0, `operandA` = 3.
- Reset mid-transaction:
  - Stimulus: drive `reset_n` low while `calcReq` = 1.
  - Required: `calcReq` = 0 with no clock edge; all outputs at reset values.
  - Stimulus: after release, `resultValid` pulse.
  - Required: `displayValue` remains 0.

Source files
------------

// File: rtl/key_entry_sequencer_if.sv
// Keypad/arithmetic-core bundle for the key entry sequencer.
// Latency: none, wires only.
// Backpressure: calcReq is held until calcAck; resultValid is a single-cycle pulse.
interface key_entry_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             newDigit;
    logic             newOp;
    logic [3:0]       clickedMatrix;
    logic             calcAck;
    logic             resultValid;
    logic [WIDTH-1:0] result;
    logic             calcErr;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [3:0]       opCode;
    logic             calcReq;
    logic [WIDTH-1:0] displayValue;
    logic             errorFlag;
    logic [2:0]       entryState;

    // Sequencer side
    modport master (
        input  newDigit, newOp, clickedMatrix, calcAck, resultValid, result, calcErr,
        output operandA, operandB, opCode, calcReq, displayValue, errorFlag, entryState
    );

    // Keypad decoder / arithmetic core / display side
    modport slave (
        output newDigit, newOp, clickedMatrix, calcAck, resultValid, result, calcErr,
        input  operandA, operandB, opCode, calcReq, displayValue, errorFlag, entryState
    );
endinterface

// File: rtl/key_entry_sequencer.sv
// Turns keypad clicks into key events, builds decimal operands, requests a calculation on '='.
// Latency: a key event detected in cycle n is visible on all registered outputs in cycle n+1.
// Backpressure: calcReq held until calcAck is sampled; key events are dropped while a calculation is in flight.
module key_entry_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    key_entry_sequencer_if.master bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [CW-1:0]    ONE_CNT = CW'(1);
    localparam logic [WIDTH-1:0] TEN     = WIDTH'(10);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        REQUEST  = 3'd2,
        WAIT_RES = 3'd3,
        SHOW_RES = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             press_q;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnta_q, cnta_d, cntb_q, cntb_d;
    logic             err_q, err_d, req_q, req_d;

    logic             press, key_evt, dig_evt, arith_evt, eq_evt;
    logic [WIDTH-1:0] code_w, acc_a, acc_b;

    // A click becomes one event on its rising edge; both lines high counts as a digit
    assign press     = bus.newDigit | bus.newOp;
    assign key_evt   = press & ~press_q;
    assign dig_evt   = key_evt & bus.newDigit & (bus.clickedMatrix <= 4'd9);
    assign arith_evt = key_evt & ~bus.newDigit & (bus.clickedMatrix >= 4'd1) & (bus.clickedMatrix <= 4'd4);
    assign eq_evt    = key_evt & ~bus.newDigit & (bus.clickedMatrix == 4'd14);
    assign code_w    = {{(WIDTH-4){1'b0}}, bus.clickedMatrix};
    assign acc_a     = a_q * TEN + code_w;
    assign acc_b     = b_q * TEN + code_w;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ENTER_A;
        else          state_q <= state_d;
    end

    // Next-state selection from key events and the core handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTER_A:  if (arith_evt) state_d = ENTER_B;
            ENTER_B:  if (eq_evt && cntb_q != '0) state_d = REQUEST;
            REQUEST:  if (bus.calcAck) state_d = WAIT_RES;
            WAIT_RES: if (bus.resultValid) state_d = SHOW_RES;
            SHOW_RES: begin
                if (dig_evt)                   state_d = ENTER_A;
                else if (arith_evt && !err_q)  state_d = ENTER_B;
            end
            default:  state_d = ENTER_A;
        endcase
    end

    // Datapath next values; digits beyond the cap leave the operand untouched
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        disp_d = disp_q;
        op_d   = op_q;
        cnta_d = cnta_q;
        cntb_d = cntb_q;
        err_d  = err_q;
        case (state_q)
            ENTER_A: begin
                if (dig_evt) begin
                    if (cnta_q < MAX_CNT) begin
                        a_d    = acc_a;
                        cnta_d = cnta_q + ONE_CNT;
                    end
                    disp_d = a_d;
                end else if (arith_evt) begin
                    op_d   = bus.clickedMatrix;
                    b_d    = '0;
                    cntb_d = '0;
                    disp_d = '0;
                end
            end
            ENTER_B: begin
                if (dig_evt) begin
                    if (cntb_q < MAX_CNT) begin
                        b_d    = acc_b;
                        cntb_d = cntb_q + ONE_CNT;
                    end
                    disp_d = b_d;
                end else if (arith_evt && cntb_q == '0) begin
                    op_d = bus.clickedMatrix;
                end
            end
            WAIT_RES: begin
                if (bus.resultValid) begin
                    disp_d = bus.result;
                    err_d  = bus.calcErr;
                end
            end
            SHOW_RES: begin
                if (dig_evt) begin
                    a_d    = code_w;
                    cnta_d = ONE_CNT;
                    err_d  = 1'b0;
                    disp_d = code_w;
                end else if (arith_evt && !err_q) begin
                    // Chain: the result becomes operand A and is closed to further digits
                    a_d    = disp_q;
                    cnta_d = MAX_CNT;
                    op_d   = bus.clickedMatrix;
                    b_d    = '0;
                    cntb_d = '0;
                    disp_d = '0;
                end
            end
            default: ;
        endcase
        req_d = (state_d == REQUEST);
    end

    // Datapath and output registers, including the click edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
            op_q    <= '0;
            cnta_q  <= '0;
            cntb_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            press_q <= press;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            op_q    <= op_d;
            cnta_q  <= cnta_d;
            cntb_q  <= cntb_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    assign bus.operandA     = a_q;
    assign bus.operandB     = b_q;
    assign bus.opCode       = op_q;
    assign bus.calcReq      = req_q;
    assign bus.displayValue = disp_q;
    assign bus.errorFlag    = err_q;
    assign bus.entryState   = state_q;
endmodule

// File: tb/tb_key_entry_sequencer.sv
// Self-checking bench for key_entry_sequencer: directed scenarios plus randomized clicks vs a key-level model.
// Latency: outputs sampled on the falling edge, one cycle after a click edge.
// Backpressure: the bench plays the arithmetic core with random ack/result delays.
module tb_key_entry_sequencer;
    localparam int W    = 16;
    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    key_entry_sequencer_if #(.WIDTH(W)) bus();
    key_entry_sequencer #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Key-level reference model: 0=ENTER_A 1=ENTER_B 2=REQUEST 3=WAIT_RES 4=SHOW_RES
    int          m_state, m_cnta, m_cntb;
    logic [15:0] m_a, m_b, m_disp;
    logic [3:0]  m_op;
    logic        m_err;

    task automatic model_reset();
        m_state = 0; m_cnta = 0; m_cntb = 0;
        m_a = 0; m_b = 0; m_disp = 0; m_op = 0; m_err = 0;
    endtask

    task automatic model_key(input bit is_dig, input int code);
        bit arith = (code >= 1 && code <= 4);
        if (is_dig) begin
            if (code > 9) return;
            if (m_state == 0) begin
                if (m_cnta < MAXD) begin m_a = m_a * 16'd10 + 16'(code); m_cnta++; end
                m_disp = m_a;
            end else if (m_state == 1) begin
                if (m_cntb < MAXD) begin m_b = m_b * 16'd10 + 16'(code); m_cntb++; end
                m_disp = m_b;
            end else if (m_state == 4) begin
                m_a = 16'(code); m_cnta = 1; m_err = 0; m_disp = 16'(code); m_state = 0;
            end
        end else begin
            if (m_state == 0 && arith) begin
                m_op = 4'(code); m_b = 0; m_cntb = 0; m_disp = 0; m_state = 1;
            end else if (m_state == 1) begin
                if (arith && m_cntb == 0) m_op = 4'(code);
                else if (code == 14 && m_cntb > 0) m_state = 2;
            end else if (m_state == 4 && arith && !m_err) begin
                m_a = m_disp; m_cnta = MAXD; m_op = 4'(code);
                m_b = 0; m_cntb = 0; m_disp = 0; m_state = 1;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.newDigit = 0; bus.newOp = 0; bus.clickedMatrix = 0;
        bus.calcAck = 0; bus.resultValid = 0; bus.result = 0; bus.calcErr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset();
        @(negedge clk);
    endtask

    // Hold a click for 'hold' cycles, release, and let the result settle
    task automatic click(input bit dig, input bit op, input int code, input int hold);
        @(negedge clk);
        bus.newDigit = dig; bus.newOp = op; bus.clickedMatrix = 4'(code);
        repeat (hold) @(negedge clk);
        bus.newDigit = 0; bus.newOp = 0;
        @(negedge clk);
        model_key(dig, code);
    endtask

    task automatic dkey(input int code); click(1, 0, code, 1); endtask
    task automatic okey(input int code); click(0, 1, code, 1); endtask

    // Arithmetic core: ack after a delay (optionally with a decoy result), then deliver the result
    task automatic serve(input logic [15:0] res, input bit e, input int ack_dly, input int rv_dly, input bit decoy);
        int n = 0;
        while (bus.calcReq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (bus.calcReq !== 1'b1) begin
            bad++; $display("FAIL serve_req_timeout calcReq=%b want 1", bus.calcReq); return;
        end
        repeat (ack_dly) @(negedge clk);
        total++;
        if (bus.calcReq !== 1'b1) begin bad++; $display("FAIL serve_req_hold calcReq=%b want 1", bus.calcReq); end
        bus.calcAck = 1;
        if (decoy) begin bus.resultValid = 1; bus.result = res ^ 16'h00FF; bus.calcErr = ~e; end
        @(negedge clk);
        bus.calcAck = 0; bus.resultValid = 0;
        m_state = 3;
        repeat (rv_dly) @(negedge clk);
        bus.resultValid = 1; bus.result = res; bus.calcErr = e;
        @(negedge clk);
        bus.resultValid = 0;
        m_state = 4; m_disp = res; m_err = e;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        #3;
        total++; if (bus.entryState !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.entryState); end
        total++; if (bus.calcReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.calcReq); end
        total++; if (bus.operandA !== 16'd0 || bus.operandB !== 16'd0 || bus.displayValue !== 16'd0)
            begin bad++; $display("FAIL reset_vals a=%0d b=%0d disp=%0d want 0", bus.operandA, bus.operandB, bus.displayValue); end
        total++; if (bus.opCode !== 4'd0 || bus.errorFlag !== 1'b0)
            begin bad++; $display("FAIL reset_op_err op=%0d err=%b want 0", bus.opCode, bus.errorFlag); end
        do_reset();
    endtask

    task automatic test_entry_request();
        do_reset();
        dkey(1); dkey(2); okey(2); dkey(3); dkey(4);
        total++; if (bus.operandA !== 16'd12) begin bad++; $display("FAIL entry_a got=%0d want=12", bus.operandA); end
        total++; if (bus.opCode !== 4'd2) begin bad++; $display("FAIL entry_op got=%0d want=2", bus.opCode); end
        total++; if (bus.operandB !== 16'd34) begin bad++; $display("FAIL entry_b got=%0d want=34", bus.operandB); end
        total++; if (bus.displayValue !== 16'd34) begin bad++; $display("FAIL entry_disp got=%0d want=34", bus.displayValue); end
        @(negedge clk);
        total++; if (bus.calcReq !== 1'b0) begin bad++; $display("FAIL req_before_eq got=%b want=0", bus.calcReq); end
        bus.newOp = 1; bus.clickedMatrix = 4'd14;
        @(negedge clk);
        total++; if (bus.calcReq !== 1'b1 || bus.entryState !== 3'd2)
            begin bad++; $display("FAIL req_rise req=%b state=%0d want 1/2", bus.calcReq, bus.entryState); end
        bus.newOp = 0;
        @(negedge clk);
        total++; if (bus.calcReq !== 1'b1) begin bad++; $display("FAIL req_hold got=%b want=1", bus.calcReq); end
        bus.calcAck = 1;
        @(negedge clk);
        bus.calcAck = 0;
        total++; if (bus.calcReq !== 1'b0 || bus.entryState !== 3'd3)
            begin bad++; $display("FAIL req_fall req=%b state=%0d want 0/3", bus.calcReq, bus.entryState); end
        bus.resultValid = 1; bus.result = 16'd46; bus.calcErr = 0;
        @(negedge clk);
        bus.resultValid = 0;
        total++; if (bus.displayValue !== 16'd46 || bus.entryState !== 3'd4)
            begin bad++; $display("FAIL result46 disp=%0d state=%0d want 46/4", bus.displayValue, bus.entryState); end
        m_state = 4; m_disp = 16'd46; m_err = 0; m_a = 16'd12; m_b = 16'd34; m_op = 4'd2;
    endtask

    task automatic test_chain_restart();
        okey(1); dkey(2); okey(14);
        serve(16'd92, 0, 1, 1, 0);
        total++; if (bus.operandA !== 16'd46) begin bad++; $display("FAIL chain_a got=%0d want=46", bus.operandA); end
        total++; if (bus.operandB !== 16'd2 || bus.opCode !== 4'd1)
            begin bad++; $display("FAIL chain_b_op b=%0d op=%0d want 2/1", bus.operandB, bus.opCode); end
        total++; if (bus.displayValue !== 16'd92) begin bad++; $display("FAIL chain_disp got=%0d want=92", bus.displayValue); end
        dkey(5);
        total++; if (bus.operandA !== 16'd5 || bus.entryState !== 3'd0)
            begin bad++; $display("FAIL restart a=%0d state=%0d want 5/0", bus.operandA, bus.entryState); end
    endtask

    task automatic test_held_click();
        do_reset();
        click(1, 0, 7, 50);
        total++; if (bus.operandA !== 16'd7) begin bad++; $display("FAIL held_a got=%0d want=7", bus.operandA); end
        click(1, 1, 6, 2);
        total++; if (bus.operandA !== 16'd76 || bus.entryState !== 3'd0)
            begin bad++; $display("FAIL both_lines a=%0d state=%0d want 76/0", bus.operandA, bus.entryState); end
        dkey(12); okey(7); okey(14);
        total++; if (bus.operandA !== 16'd76 || bus.entryState !== 3'd0)
            begin bad++; $display("FAIL bad_codes a=%0d state=%0d want 76/0", bus.operandA, bus.entryState); end
    endtask

    task automatic test_digit_cap();
        do_reset();
        dkey(9); dkey(8); dkey(7); dkey(6); dkey(5);
        total++; if (bus.operandA !== 16'd9876) begin bad++; $display("FAIL cap_a got=%0d want=9876", bus.operandA); end
        total++; if (bus.displayValue !== 16'd9876) begin bad++; $display("FAIL cap_disp got=%0d want=9876", bus.displayValue); end
    endtask

    task automatic test_enter_b_rules();
        do_reset();
        dkey(5); okey(2); okey(3); okey(14);
        total++; if (bus.opCode !== 4'd3 || bus.entryState !== 3'd1 || bus.calcReq !== 1'b0)
            begin bad++; $display("FAIL b_empty op=%0d state=%0d req=%b want 3/1/0", bus.opCode, bus.entryState, bus.calcReq); end
        dkey(1); okey(1);
        total++; if (bus.opCode !== 4'd3 || bus.operandB !== 16'd1)
            begin bad++; $display("FAIL b_op_locked op=%0d b=%0d want 3/1", bus.opCode, bus.operandB); end
    endtask

    task automatic test_error_path();
        do_reset();
        dkey(8); okey(4); dkey(0); okey(14);
        serve(16'd0, 1, 0, 0, 0);
        total++; if (bus.errorFlag !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.errorFlag); end
        okey(2);
        total++; if (bus.entryState !== 3'd4 || bus.opCode !== 4'd4)
            begin bad++; $display("FAIL err_op_ignored state=%0d op=%0d want 4/4", bus.entryState, bus.opCode); end
        dkey(3);
        total++; if (bus.errorFlag !== 1'b0 || bus.operandA !== 16'd3)
            begin bad++; $display("FAIL err_clear err=%b a=%0d want 0/3", bus.errorFlag, bus.operandA); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dkey(1); okey(2); dkey(1); okey(14);
        total++; if (bus.calcReq !== 1'b1) begin bad++; $display("FAIL mid_req_up got=%b want=1", bus.calcReq); end
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        total++; if (bus.calcReq !== 1'b0) begin bad++; $display("FAIL mid_req_drop got=%b want=0", bus.calcReq); end
        total++; if (bus.entryState !== 3'd0 || bus.operandA !== 16'd0 || bus.operandB !== 16'd0 || bus.opCode !== 4'd0)
            begin bad++; $display("FAIL mid_clear state=%0d a=%0d b=%0d op=%0d want 0", bus.entryState, bus.operandA, bus.operandB, bus.opCode); end
        @(negedge clk);
        reset_n = 1;
        model_reset();
        bus.resultValid = 1; bus.result = 16'd1234;
        @(negedge clk);
        bus.resultValid = 0;
        @(negedge clk);
        total++; if (bus.displayValue !== 16'd0 || bus.entryState !== 3'd0)
            begin bad++; $display("FAIL late_result disp=%0d state=%0d want 0/0", bus.displayValue, bus.entryState); end
    endtask

    task automatic test_random();
        int ops[6] = '{1, 2, 3, 4, 14, 14};
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            int code;
            if (r < 50) begin
                code = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                click(1, ($urandom_range(0, 9) == 0), code, $urandom_range(1, 4));
            end else if (r < 90) begin
                code = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : $urandom_range(0, 15);
                click(0, 1, code, $urandom_range(1, 4));
            end else begin
                // Stray result pulse outside WAIT_RES must be dropped
                @(negedge clk);
                bus.resultValid = 1; bus.result = 16'($urandom); bus.calcErr = 1'($urandom);
                @(negedge clk);
                bus.resultValid = 0;
            end
            if (m_state == 2)
                serve(16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom));
            total++; if (bus.entryState !== 3'(m_state)) begin bad++; $display("FAIL rnd_state i=%0d got=%0d want=%0d", i, bus.entryState, m_state); end
            total++; if (bus.operandA !== m_a) begin bad++; $display("FAIL rnd_a i=%0d got=%0d want=%0d", i, bus.operandA, m_a); end
            total++; if (bus.operandB !== m_b) begin bad++; $display("FAIL rnd_b i=%0d got=%0d want=%0d", i, bus.operandB, m_b); end
            total++; if (bus.opCode !== m_op) begin bad++; $display("FAIL rnd_op i=%0d got=%0d want=%0d", i, bus.opCode, m_op); end
            total++; if (bus.displayValue !== m_disp) begin bad++; $display("FAIL rnd_disp i=%0d got=%0d want=%0d", i, bus.displayValue, m_disp); end
            total++; if (bus.errorFlag !== m_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b want=%b", i, bus.errorFlag, m_err); end
            total++; if (bus.calcReq !== (m_state == 2)) begin bad++; $display("FAIL rnd_req i=%0d got=%b want=%b", i, bus.calcReq, (m_state == 2)); end
        end
    endtask

    initial begin
        test_reset();
        test_entry_request();
        test_chain_restart();
        test_held_click();
        test_digit_cap();
        test_enter_b_rules();
        test_error_path();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
